spi_slave_if: RTL and testbench

SPI_SLAVE_IF -- requirements
Module: spi_slave_if

---
 rtl/spi_slave_if.sv | 121 ++++++++++++
 tb/tb_spi_slave_if.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave, oversampled by the system clock: synchronizes cs/sck/mosi,
// shifts one WIDTH-bit word each way per frame and flags frames of the wrong length.
`timescale 1ns/1ps
module spi_slave_if #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] FILL  = 16'h0000
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             cs,
    input  logic             sck,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ack,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             busy
);
    localparam int             CW       = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic             cs_s1, cs_s2, cs_d;
    logic             sck_s1, sck_s2, sck_d;
    logic             mosi_s1, mosi_s2;
    logic             cs_seen_high;
    logic [WIDTH-1:0] tx_shift;
    logic [WIDTH-1:0] rx_shift;
    logic [CW-1:0]    bit_cnt;

    logic cs_fall, cs_rise, sck_rise, sck_fall;

    assign cs_fall  = cs_d & ~cs_s2;
    assign cs_rise  = ~cs_d & cs_s2;
    assign sck_rise = ~sck_d & sck_s2;
    assign sck_fall = sck_d & ~sck_s2;

    // The cs synchronizer clears to 0, so the pad is only enabled once cs has been seen high
    // since reset; otherwise a cs held low through reset would drive miso without a frame.
    assign miso_oe = ~cs_s2 & cs_seen_high;
    assign miso    = (state == SHIFT && bit_cnt < CNT_FULL) ? tx_shift[WIDTH-1] : 1'b0;
    assign busy    = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state        <= IDLE;
            cs_s1        <= 1'b0;
            cs_s2        <= 1'b0;
            cs_d         <= 1'b0;
            sck_s1       <= 1'b0;
            sck_s2       <= 1'b0;
            sck_d        <= 1'b0;
            mosi_s1      <= 1'b0;
            mosi_s2      <= 1'b0;
            cs_seen_high <= 1'b0;
            tx_shift     <= '0;
            rx_shift     <= '0;
            bit_cnt      <= '0;
            rx_data      <= '0;
            tx_ack       <= 1'b0;
            rx_valid     <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            cs_s1   <= cs;
            cs_s2   <= cs_s1;
            cs_d    <= cs_s2;
            sck_s1  <= sck;
            sck_s2  <= sck_s1;
            sck_d   <= sck_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            if (cs_s2) cs_seen_high <= 1'b1;

            tx_ack    <= 1'b0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (cs_fall) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                        if (tx_valid) begin
                            tx_shift <= tx_data;
                            tx_ack   <= 1'b1;
                        end else begin
                            tx_shift <= FILL;
                        end
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state <= DONE;
                        if (bit_cnt == CNT_FULL) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        if (sck_fall) tx_shift <= {tx_shift[WIDTH-2:0], 1'b0};
                        // Counting continues one past WIDTH so overlong frames stay detectable.
                        if (sck_rise) begin
                            if (bit_cnt < CNT_FULL) rx_shift <= {rx_shift[WIDTH-2:0], mosi_s2};
                            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_if.sv
// Self-checking bench for spi_slave_if: a bit-level SPI master drives random frames and
// the expected miso stream, pulse counts and rx_data come from a word-level model.
`timescale 1ns/1ps
module tb_spi_slave_if;
    localparam int          WIDTH = 16;
    localparam logic [15:0] FILL  = 16'h0000;
    localparam int          HALF  = 5;

    logic        clk = 1'b0;
    logic        rst_in, cs, sck, mosi, miso, miso_oe;
    logic        tx_valid, tx_ack, rx_valid, frame_err, busy;
    logic [15:0] tx_data, rx_data;

    int          total = 0;
    int          bad = 0;
    int          ack_cnt = 0;
    int          rxv_cnt = 0;
    int          ferr_cnt = 0;
    int          excl_bad = 0;
    logic [15:0] model_rx = 16'h0000;
    logic        oe_sample = 1'b0;

    always #5 clk = ~clk;

    spi_slave_if #(.WIDTH(WIDTH), .FILL(FILL)) dut (
        .clk(clk), .rst_in(rst_in), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ack(tx_ack), .rx_data(rx_data), .rx_valid(rx_valid),
        .frame_err(frame_err), .busy(busy)
    );

    // Pulse counters sampled away from the active edge; tests work on differences.
    always @(negedge clk) begin
        if (tx_ack === 1'b1) ack_cnt++;
        if (rx_valid === 1'b1) rxv_cnt++;
        if (frame_err === 1'b1) ferr_cnt++;
        if ((int'(tx_ack === 1'b1) + int'(rx_valid === 1'b1) + int'(frame_err === 1'b1)) > 1) excl_bad++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: time %0t exceeded limit 2000000", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] exp_miso(input int nbits, input logic valid, input logic [15:0] data);
        logic [15:0] w;
        logic [31:0] e;
        w = valid ? data : FILL;
        e = '0;
        for (int i = 0; i < nbits; i++) e = {e[30:0], (i < WIDTH) ? w[WIDTH-1-i] : 1'b0};
        return e;
    endfunction

    task automatic spi_bits(input int nbits, input logic [31:0] word, output logic [31:0] cap);
        cap = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = word[nbits-1-i];
            repeat (HALF) @(negedge clk);
            if (i == 0) oe_sample = miso_oe;
            cap = {cap[30:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic do_frame(input int nbits, input logic valid, input logic [15:0] data,
                            input logic [31:0] word, output logic [31:0] cap,
                            output int acks, output int rxvs, output int ferrs);
        int a0, r0, f0;
        a0 = ack_cnt; r0 = rxv_cnt; f0 = ferr_cnt;
        tx_valid = valid;
        tx_data  = data;
        cs = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(nbits, word, cap);
        repeat (HALF) @(negedge clk);
        cs = 1'b1;
        tx_valid = 1'b0;
        repeat (8) @(negedge clk);
        acks = ack_cnt - a0; rxvs = rxv_cnt - r0; ferrs = ferr_cnt - f0;
        if (nbits == WIDTH) model_rx = word[15:0];
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk);
        total += 7;
        if (miso !== 1'b0)       begin bad++; $display("[TB] FAIL reset_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0)    begin bad++; $display("[TB] FAIL reset_miso_oe: got %b expected 0", miso_oe); end
        if (tx_ack !== 1'b0)     begin bad++; $display("[TB] FAIL reset_tx_ack: got %b expected 0", tx_ack); end
        if (rx_valid !== 1'b0)   begin bad++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        if (frame_err !== 1'b0)  begin bad++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        if (busy !== 1'b0)       begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        if (rx_data !== 16'h0)   begin bad++; $display("[TB] FAIL reset_rx_data: got %h expected 0000", rx_data); end
        rst_in = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] cap;
        int acks, rxvs, ferrs;
        do_frame(16, 1'b1, 16'hA5C3, 32'h1234, cap, acks, rxvs, ferrs);
        total += 6;
        if (cap[15:0] !== 16'hA5C3) begin bad++; $display("[TB] FAIL basic_miso: got %h expected a5c3", cap[15:0]); end
        if (acks !== 1)  begin bad++; $display("[TB] FAIL basic_tx_ack: got %0d pulses expected 1", acks); end
        if (rxvs !== 1)  begin bad++; $display("[TB] FAIL basic_rx_valid: got %0d pulses expected 1", rxvs); end
        if (ferrs !== 0) begin bad++; $display("[TB] FAIL basic_frame_err: got %0d pulses expected 0", ferrs); end
        if (rx_data !== 16'h1234) begin bad++; $display("[TB] FAIL basic_rx_data: got %h expected 1234", rx_data); end
        if (oe_sample !== 1'b1) begin bad++; $display("[TB] FAIL basic_miso_oe: got %b expected 1", oe_sample); end
    endtask

    task automatic test_fill();
        logic [31:0] cap, word;
        int acks, rxvs, ferrs;
        word = $urandom;
        do_frame(16, 1'b0, 16'hFFFF, word, cap, acks, rxvs, ferrs);
        total += 4;
        if (cap[15:0] !== FILL) begin bad++; $display("[TB] FAIL fill_miso: got %h expected %h", cap[15:0], FILL); end
        if (acks !== 0) begin bad++; $display("[TB] FAIL fill_tx_ack: got %0d pulses expected 0", acks); end
        if (rxvs !== 1) begin bad++; $display("[TB] FAIL fill_rx_valid: got %0d pulses expected 1", rxvs); end
        if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL fill_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_short_frame();
        logic [31:0] cap;
        int acks, rxvs, ferrs;
        do_frame(12, 1'b1, 16'($urandom), $urandom, cap, acks, rxvs, ferrs);
        total += 3;
        if (ferrs !== 1) begin bad++; $display("[TB] FAIL short_frame_err: got %0d pulses expected 1", ferrs); end
        if (rxvs !== 0)  begin bad++; $display("[TB] FAIL short_rx_valid: got %0d pulses expected 0", rxvs); end
        if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL short_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_long_frame();
        logic [31:0] cap, exp;
        logic [15:0] data;
        int acks, rxvs, ferrs;
        data = 16'($urandom);
        exp  = exp_miso(20, 1'b1, data);
        do_frame(20, 1'b1, data, $urandom, cap, acks, rxvs, ferrs);
        total += 4;
        if (cap !== exp) begin bad++; $display("[TB] FAIL long_miso: got %h expected %h", cap, exp); end
        if (ferrs !== 1) begin bad++; $display("[TB] FAIL long_frame_err: got %0d pulses expected 1", ferrs); end
        if (rxvs !== 0)  begin bad++; $display("[TB] FAIL long_rx_valid: got %0d pulses expected 0", rxvs); end
        if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL long_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_random();
        logic [31:0] cap, exp, word;
        logic [15:0] data;
        logic        valid;
        int          nbits, acks, rxvs, ferrs;
        for (int k = 0; k < 8; k++) begin
            nbits = ($urandom_range(0, 1) == 0) ? WIDTH : int'($urandom_range(0, 20));
            valid = 1'($urandom_range(0, 1));
            data  = 16'($urandom);
            word  = $urandom;
            exp   = exp_miso(nbits, valid, data);
            do_frame(nbits, valid, data, word, cap, acks, rxvs, ferrs);
            total += 5;
            if (cap !== exp) begin bad++; $display("[TB] FAIL rand_miso[%0d]: got %h expected %h (%0d bits)", k, cap, exp, nbits); end
            if (acks !== int'(valid)) begin bad++; $display("[TB] FAIL rand_tx_ack[%0d]: got %0d expected %0d", k, acks, int'(valid)); end
            if (rxvs !== int'(nbits == WIDTH)) begin bad++; $display("[TB] FAIL rand_rx_valid[%0d]: got %0d expected %0d", k, rxvs, int'(nbits == WIDTH)); end
            if (ferrs !== int'(nbits != WIDTH)) begin bad++; $display("[TB] FAIL rand_frame_err[%0d]: got %0d expected %0d", k, ferrs, int'(nbits != WIDTH)); end
            if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL rand_rx_data[%0d]: got %h expected %h", k, rx_data, model_rx); end
        end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] cap, word;
        logic [15:0] data;
        int r0, f0, a0, busy_cycles, acks, rxvs, ferrs;
        r0 = rxv_cnt; f0 = ferr_cnt;
        tx_valid = 1'b1;
        tx_data  = 16'($urandom);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(8, $urandom, cap);
        rst_in = 1'b1;
        @(negedge clk);
        model_rx = 16'h0000;
        total += 5;
        if (busy !== 1'b0)    begin bad++; $display("[TB] FAIL abort_busy: got %b expected 0", busy); end
        if (miso !== 1'b0)    begin bad++; $display("[TB] FAIL abort_miso: got %b expected 0", miso); end
        if (miso_oe !== 1'b0) begin bad++; $display("[TB] FAIL abort_miso_oe: got %b expected 0", miso_oe); end
        if (rx_data !== 16'h0) begin bad++; $display("[TB] FAIL abort_rx_data: got %h expected 0000", rx_data); end
        if ((rxv_cnt - r0) + (ferr_cnt - f0) !== 0) begin bad++; $display("[TB] FAIL abort_pulses: got %0d expected 0", (rxv_cnt - r0) + (ferr_cnt - f0)); end
        @(negedge clk);
        rst_in = 1'b0;
        a0 = ack_cnt;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_cycles++;
        end
        total += 2;
        if (busy_cycles !== 0) begin bad++; $display("[TB] FAIL held_cs_busy: got %0d busy cycles expected 0", busy_cycles); end
        if (ack_cnt - a0 !== 0) begin bad++; $display("[TB] FAIL held_cs_tx_ack: got %0d pulses expected 0", ack_cnt - a0); end
        tx_valid = 1'b0;
        cs = 1'b1;
        repeat (8) @(negedge clk);
        data = 16'($urandom);
        word = $urandom;
        do_frame(16, 1'b1, data, word, cap, acks, rxvs, ferrs);
        total += 3;
        if (cap[15:0] !== data) begin bad++; $display("[TB] FAIL after_reset_miso: got %h expected %h", cap[15:0], data); end
        if (rxvs !== 1) begin bad++; $display("[TB] FAIL after_reset_rx_valid: got %0d expected 1", rxvs); end
        if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL after_reset_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] cap, w1, w2;
        logic [15:0] data;
        int a0, r0, acks, rxvs, ferrs;
        w1 = $urandom;
        a0 = ack_cnt; r0 = rxv_cnt;
        tx_valid = 1'b1;
        tx_data  = 16'($urandom);
        cs = 1'b0;
        repeat (6) @(negedge clk);
        spi_bits(16, w1, cap);
        repeat (HALF) @(negedge clk);
        // One clk of cs high puts the second synchronized fall into the DONE cycle.
        cs = 1'b1;
        @(negedge clk);
        cs = 1'b0;
        repeat (10) @(negedge clk);
        total += 4;
        if (busy !== 1'b0) begin bad++; $display("[TB] FAIL b2b_ignored_busy: got %b expected 0", busy); end
        if (ack_cnt - a0 !== 1) begin bad++; $display("[TB] FAIL b2b_tx_ack: got %0d pulses expected 1", ack_cnt - a0); end
        if (rxv_cnt - r0 !== 1) begin bad++; $display("[TB] FAIL b2b_rx_valid: got %0d pulses expected 1", rxv_cnt - r0); end
        if (rx_data !== w1[15:0]) begin bad++; $display("[TB] FAIL b2b_first_rx_data: got %h expected %h", rx_data, w1[15:0]); end
        model_rx = w1[15:0];
        tx_valid = 1'b0;
        cs = 1'b1;
        repeat (8) @(negedge clk);
        data = 16'($urandom);
        w2 = $urandom;
        do_frame(16, 1'b1, data, w2, cap, acks, rxvs, ferrs);
        total += 3;
        if (cap[15:0] !== data) begin bad++; $display("[TB] FAIL b2b_fresh_miso: got %h expected %h", cap[15:0], data); end
        if (acks !== 1) begin bad++; $display("[TB] FAIL b2b_fresh_tx_ack: got %0d expected 1", acks); end
        if (rx_data !== model_rx) begin bad++; $display("[TB] FAIL b2b_fresh_rx_data: got %h expected %h", rx_data, model_rx); end
    endtask

    task automatic test_exclusive();
        total++;
        if (excl_bad !== 0) begin bad++; $display("[TB] FAIL pulse_exclusive: got %0d overlapping cycles expected 0", excl_bad); end
    endtask

    initial begin
        rst_in = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
        tx_valid = 1'b0; tx_data = 16'h0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_fill();
        test_short_frame();
        test_long_frame();
        test_random();
        test_reset_midframe();
        test_back_to_back();
        test_exclusive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
